uart_rx_buf: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 88 ++++++++
 rtl/uart_rx_buf.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART receive path.
//   - rx_state_e   : receiver FSM state encoding (3 bits)
//   - UART_DATA_BITS: number of data bits per frame
//   - calcHalf()   : offset in clocks from start-bit detection to the
//                    start-bit mid-point check
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    // Floor of half a bit period; the start bit is re-checked here to
    // reject glitches shorter than half a bit.
    function automatic int calcHalf(input int clkPerBit);
        return clkPerBit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through receive FIFO built from a register array.
// The head entry is always visible on dout while the FIFO is non-empty.
//
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (empties the FIFO)
//   push   : write din this cycle (ignored when full unless a pop coincides)
//   din    : data to write
//   pop    : remove the head entry (ignored when empty)
//   dout   : head entry, forced to zero while empty
//   empty  : no entries held
//   full   : FIFO_DEPTH entries held
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W:0]    count_q;
    logic [PTR_W:0]    count_d;
    logic              doPush;
    logic              doPop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Zero while empty so the visible head matches the reset state.
    assign dout = empty ? '0 : mem_q[rdPtr_q];

    // Occupancy: the extra bit separates full from empty when the
    // pointers are equal.
    always_comb begin
        count_d = count_q;
        unique case ({doPush, doPop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset; stale entries are never visible because
    // dout is masked while empty.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_buf.sv
// ---------------------------------------------------------------------------
// uart_rx_buf
// 8N1 UART receiver with a small FWFT receive FIFO and sticky error flags.
// Bytes are assembled LSB-first at CLK_PER_BIT clocks per bit.
//
// Ports:
//   wb_clk_i  : clock
//   wb_rst_i  : synchronous active-high reset
//   rxd       : asynchronous serial input, idles high
//   rx_data   : FIFO head byte, meaningful while rx_valid=1
//   rx_valid  : FIFO non-empty
//   rx_ready  : consumer pops the head when rx_valid && rx_ready
//   frame_err : sticky, a stop bit was sampled low
//   overrun   : sticky, a received byte was dropped because the FIFO was full
//   err_clr   : clears both sticky flags on the next edge (a new error wins)
//   busy      : receiver FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_buf
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(calcHalf(CLK_PER_BIT));
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync_q;
    logic                      rxS;
    rx_state_e                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bitCnt_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      push_q;
    logic                      frameErr_q;
    logic                      overrun_q;
    logic                      fifoEmpty;
    logic                      fifoFull;
    logic                      fifoPop;

    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never manufactures a start bit.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rxS = sync_q[1];

    // Receiver FSM. push_q is a one-cycle registered strobe that hands the
    // completed byte in shift_q to the FIFO. The error clear is applied
    // before the state logic so a coincident framing error still sets the
    // flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (err_clr) begin
                frameErr_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (!rxS) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (!rxS) begin
                            state_q  <= DATA;
                            bitCnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rxS, shift_q[UART_DATA_BITS-1:1]};
                        if (bitCnt_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (rxS) begin
                            push_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until the line returns high so a break is not
                    // mistaken for a fresh start bit.
                    if (rxS) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifoPop = rx_ready && !fifoEmpty;

    // Overrun only when the byte is really dropped: a pop in the same cycle
    // makes room and the FIFO accepts the push.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            overrun_q <= 1'b0;
        end else begin
            if (err_clr) begin
                overrun_q <= 1'b0;
            end
            if (push_q && fifoFull && !fifoPop) begin
                overrun_q <= 1'b1;
            end
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DATA_W    (UART_DATA_BITS)
    ) u_fifo (
        .clk_i(wb_clk_i),
        .rst_i(wb_rst_i),
        .push (push_q),
        .din  (shift_q),
        .pop  (fifoPop),
        .dout (rx_data),
        .empty(fifoEmpty),
        .full (fifoFull)
    );

    assign rx_valid  = !fifoEmpty;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
